delta_decoder: RTL and testbench

//   Reconstructs an unsigned sample stream from the signed difference stream

---
 rtl/delta_decoder.sv | 98 +++++++++
 tb/tb_delta_decoder.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/delta_decoder.sv
// delta_decoder: rebuilds an unsigned sample stream from a frame seed followed
// by signed differences, one word per cycle with valid/ready on both sides.
//
// state | meaning
// SEED  | next accepted word is the absolute seed of a new frame
// RUN   | next accepted word is a difference added to prev
module delta_decoder #(
  parameter int DW       = 8,
  parameter bit SATURATE = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW:0]      in_diff,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_sample,
  output logic             out_first,
  output logic             out_last,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic {SEED = 1'b0, RUN = 1'b1} state_t;

  state_t               state, state_nx;
  logic [DW-1:0]        prev;
  logic [CNT_W-1:0]     counter;
  logic                 fire_in;
  logic signed [DW+1:0] sum;
  logic [DW-1:0]        sample_nx;
  logic                 ovf_nx;
  logic                 first_nx;
  logic [CNT_W-1:0]     count_nx;

  assign in_ready = !out_valid || out_ready;
  assign fire_in  = in_valid && in_ready;

  // prev zero-extended, difference sign-extended: DW+2 bits hold both extremes
  assign sum = $signed({2'b00, prev}) + $signed({in_diff[DW], in_diff});

  always_comb begin
    state_nx  = state;
    sample_nx = sum[DW-1:0];
    ovf_nx    = 1'b0;
    first_nx  = 1'b0;
    count_nx  = counter;
    if (state == SEED) begin
      sample_nx = in_diff[DW-1:0];
      first_nx  = 1'b1;
      count_nx  = '0;
    end else begin
      // low DW bits of sum are already the wrapped result
      if (sum[DW+1]) begin
        ovf_nx = 1'b1;
        if (SATURATE) sample_nx = '0;
      end else if (sum[DW]) begin
        ovf_nx = 1'b1;
        if (SATURATE) sample_nx = '1;
      end
      count_nx = (&counter) ? counter : counter + 1'b1;
    end
    if (fire_in) state_nx = in_last ? SEED : RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SEED;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_sample <= '0;
      out_first  <= 1'b0;
      out_last   <= 1'b0;
      out_ovf    <= 1'b0;
      out_count  <= '0;
      prev       <= '0;
      counter    <= '0;
    end else if (fire_in) begin
      out_valid  <= 1'b1;
      out_sample <= sample_nx;
      out_first  <= first_nx;
      out_last   <= in_last;
      out_ovf    <= ovf_nx;
      out_count  <= count_nx;
      prev       <= sample_nx;
      counter    <= count_nx;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_delta_decoder.sv
// Bench for delta_decoder: saturating, wrapping and narrow-counter variants
// share one input stream and are checked against an arithmetic reference.
`timescale 1ns/1ps
module tb_delta_decoder;

  typedef struct {
    int sample;
    bit ovf;
    bit first;
    bit last;
    int count;
  } rec_t;

  typedef struct {
    logic [8:0] diff;
    bit         last;
    int         s_sat;
    bit         o_sat;
    int         s_wrap;
    bit         o_wrap;
    bit         first;
    int         count;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;
  logic [8:0]  in_diff = '0;
  logic [2:0]  rdy, vld, first, last, ovf;
  logic [7:0]  smp [3];
  logic [15:0] cnt_s, cnt_w;
  logic [1:0]  cnt_c;

  int errors = 0;
  int checks = 0;

  delta_decoder #(.DW(8), .SATURATE(1'b1), .CNT_W(16)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_diff(in_diff), .in_last(in_last), .out_valid(vld[0]), .out_ready(out_ready),
    .out_sample(smp[0]), .out_first(first[0]), .out_last(last[0]), .out_ovf(ovf[0]),
    .out_count(cnt_s));

  delta_decoder #(.DW(8), .SATURATE(1'b0), .CNT_W(16)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_diff(in_diff), .in_last(in_last), .out_valid(vld[1]), .out_ready(out_ready),
    .out_sample(smp[1]), .out_first(first[1]), .out_last(last[1]), .out_ovf(ovf[1]),
    .out_count(cnt_w));

  delta_decoder #(.DW(8), .SATURATE(1'b1), .CNT_W(2)) u_cnt (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_diff(in_diff), .in_last(in_last), .out_valid(vld[2]), .out_ready(out_ready),
    .out_sample(smp[2]), .out_first(first[2]), .out_last(last[2]), .out_ovf(ovf[2]),
    .out_count(cnt_c));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1);
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_rec(input string name, input rec_t g, input rec_t e);
    checks++;
    if (g.sample != e.sample || g.ovf != e.ovf || g.first != e.first ||
        g.last != e.last || g.count != e.count) begin
      errors++;
      $display("FAIL %s: got sample=%0d ovf=%0d first=%0d last=%0d count=%0d, expected sample=%0d ovf=%0d first=%0d last=%0d count=%0d",
               name, g.sample, g.ovf, g.first, g.last, g.count,
               e.sample, e.ovf, e.first, e.last, e.count);
    end
  endtask

  function automatic rec_t mk_rec(input logic [7:0] s, input bit o, input bit f,
                                  input bit l, input int c);
    rec_t r;
    r.sample = int'(s);
    r.ovf    = o;
    r.first  = f;
    r.last   = l;
    r.count  = c;
    return r;
  endfunction

  function automatic vec_t mkv(input logic [8:0] d, input bit l, input int ss, input bit os,
                               input int sw, input bit ow, input bit f, input int c);
    vec_t v;
    v.diff = d; v.last = l; v.s_sat = ss; v.o_sat = os;
    v.s_wrap = sw; v.o_wrap = ow; v.first = f; v.count = c;
    return v;
  endfunction

  // Reference: plain integer arithmetic on sample values and frame index.
  function automatic rec_t ref_word(input int prev, input int d, input bit seed, input bit lst,
                                    input bit sat, input int idx, input int cmax);
    rec_t r;
    int s;
    r.first = seed;
    r.last  = lst;
    r.count = (idx > cmax) ? cmax : idx;
    if (seed) begin
      r.sample = d & 255;
      r.ovf    = 1'b0;
    end else begin
      s     = prev + d;
      r.ovf = (s < 0) || (s > 255);
      if (!r.ovf)   r.sample = s;
      else if (sat) r.sample = (s < 0) ? 0 : 255;
      else          r.sample = ((s % 256) + 256) % 256;
    end
    return r;
  endfunction

  rec_t q [3][$];
  rec_t got [3];
  rec_t held [3];
  rec_t r_new;
  bit   held_v [3];
  int   m_prev [3];
  bit   m_seed = 1'b1;
  int   m_idx = 0;
  int   idx;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        q[k].delete();
        held_v[k] = 1'b0;
        m_prev[k] = 0;
      end
      m_seed = 1'b1;
      m_idx  = 0;
    end else begin
      got[0] = mk_rec(smp[0], ovf[0], first[0], last[0], int'(cnt_s));
      got[1] = mk_rec(smp[1], ovf[1], first[1], last[1], int'(cnt_w));
      got[2] = mk_rec(smp[2], ovf[2], first[2], last[2], int'(cnt_c));
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("in_ready_rule%0d", k), int'(rdy[k]), int'(!vld[k] || out_ready));
        if (held_v[k]) begin
          chk($sformatf("hold_valid%0d", k), int'(vld[k]), 1);
          chk_rec($sformatf("hold_fields%0d", k), got[k], held[k]);
        end
        if (vld[k] && out_ready) begin
          if (q[k].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output%0d: got sample %0d, expected no output", k, got[k].sample);
          end else begin
            chk_rec($sformatf("scoreboard%0d", k), got[k], q[k].pop_front());
          end
        end
        held_v[k] = vld[k] && !out_ready;
        held[k]   = got[k];
      end
      if (in_valid && rdy[0]) begin
        idx = m_seed ? 0 : m_idx + 1;
        for (int k = 0; k < 3; k++) begin
          r_new = ref_word(m_prev[k], int'($signed(in_diff)), m_seed, in_last,
                           k != 1, idx, (k == 2) ? 3 : 65535);
          q[k].push_back(r_new);
          m_prev[k] = r_new.sample;
        end
        m_idx  = idx;
        m_seed = in_last;
      end
    end
  end

  task automatic send(input logic [8:0] d, input bit l);
    int n = 0;
    in_valid = 1'b1;
    in_diff  = d;
    in_last  = l;
    @(negedge clk);
    while (!rdy[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[0]) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready low for %0d cycles, required 1", n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    vec_t tv [$];
    int   stalls;
    int   sent;
    int   d;
    bit   fired;

    tv.push_back(mkv(9'h00A, 1'b0,  10, 1'b0,  10, 1'b0, 1'b1, 0));
    tv.push_back(mkv(9'h00A, 1'b0,  20, 1'b0,  20, 1'b0, 1'b0, 1));
    tv.push_back(mkv(9'h1FB, 1'b0,  15, 1'b0,  15, 1'b0, 1'b0, 2));
    tv.push_back(mkv(9'h014, 1'b1,  35, 1'b0,  35, 1'b0, 1'b0, 3));
    tv.push_back(mkv(9'h0FA, 1'b0, 250, 1'b0, 250, 1'b0, 1'b1, 0));
    tv.push_back(mkv(9'h00A, 1'b0, 255, 1'b1,   4, 1'b1, 1'b0, 1));
    tv.push_back(mkv(9'h001, 1'b0, 255, 1'b1,   5, 1'b0, 1'b0, 2));
    tv.push_back(mkv(9'h100, 1'b0,   0, 1'b1,   5, 1'b1, 1'b0, 3));
    tv.push_back(mkv(9'h003, 1'b1,   3, 1'b0,   8, 1'b0, 1'b0, 4));
    tv.push_back(mkv(9'h007, 1'b1,   7, 1'b0,   7, 1'b0, 1'b1, 0));
    tv.push_back(mkv(9'h164, 1'b0, 100, 1'b0, 100, 1'b0, 1'b1, 0));
    tv.push_back(mkv(9'h19C, 1'b1,   0, 1'b0,   0, 1'b0, 1'b0, 1));
    tv.push_back(mkv(9'h000, 1'b0,   0, 1'b0,   0, 1'b0, 1'b1, 0));
    tv.push_back(mkv(9'h0FF, 1'b1, 255, 1'b0, 255, 1'b0, 1'b0, 1));

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_valid%0d", k), int'(vld[k]), 0);
      chk($sformatf("reset_sample%0d", k), int'(smp[k]), 0);
      chk($sformatf("reset_flags%0d", k), int'({first[k], last[k], ovf[k]}), 0);
    end
    chk("reset_count", int'(cnt_s), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (tv[i]) begin
      send(tv[i].diff, tv[i].last);
      @(negedge clk);
      chk($sformatf("tv%0d_valid", i), int'(vld[0]), 1);
      chk($sformatf("tv%0d_sat_sample", i), int'(smp[0]), tv[i].s_sat);
      chk($sformatf("tv%0d_sat_ovf", i), int'(ovf[0]), int'(tv[i].o_sat));
      chk($sformatf("tv%0d_wrap_sample", i), int'(smp[1]), tv[i].s_wrap);
      chk($sformatf("tv%0d_wrap_ovf", i), int'(ovf[1]), int'(tv[i].o_wrap));
      chk($sformatf("tv%0d_first", i), int'(first[0]), int'(tv[i].first));
      chk($sformatf("tv%0d_last", i), int'(last[0]), int'(tv[i].last));
      chk($sformatf("tv%0d_count", i), int'(cnt_s), tv[i].count);
      chk($sformatf("tv%0d_count_narrow", i), int'(cnt_c), (tv[i].count > 3) ? 3 : tv[i].count);
      @(posedge clk);
      #1;
    end

    // Back-pressure: five stalled cycles, then one word per cycle again.
    stalls = 0;
    fork
      begin
        for (int i = 0; i < 10; i++) send((i == 0) ? 9'd50 : 9'd3, i == 9);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin
        repeat (40) begin
          @(negedge clk);
          if (in_valid && !rdy[0]) stalls++;
        end
      end
    join
    chk("stall_cycles", stalls, 5);
    @(posedge clk);
    #1;

    // Reset while an output is pending, then a fresh seed.
    send(9'd30, 1'b0);
    send(9'd5, 1'b0);
    out_ready = 1'b0;
    @(negedge clk);
    chk("pending_valid", int'(vld[0]), 1);
    chk("pending_sample", int'(smp[0]), 35);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_valid", int'(vld[0] | vld[1]), 0);
    chk("midreset_sample", int'(smp[0]), 0);
    chk("midreset_count", int'(cnt_s), 0);
    chk("midreset_flags", int'({first[0], last[0], ovf[0]}), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    send(9'h1AB, 1'b1);
    @(negedge clk);
    chk("post_reset_seed_sample", int'(smp[0]), 171);
    chk("post_reset_seed_first", int'(first[0]), 1);
    chk("post_reset_seed_count", int'(cnt_s), 0);
    @(posedge clk);
    #1;

    // Random traffic with random back-pressure; inputs held until accepted.
    fired = 1'b0;
    sent  = 0;
    for (int c = 0; c < 4000 && sent < 400; c++) begin
      if (!in_valid || fired) begin
        in_valid = ($urandom_range(3) != 0);
        d = ($urandom_range(1) != 0) ? int'($urandom_range(511)) : int'($urandom_range(40)) - 20;
        in_diff = 9'(d);
        in_last = ($urandom_range(7) == 0);
      end
      out_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      fired = in_valid && rdy[0];
      if (fired) sent++;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("random_words_sent", sent, 400);
    for (int k = 0; k < 3; k++) chk($sformatf("drained%0d", k), q[k].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
